// File: rtl/pattern_detector.sv
// rtl/pattern_detector.sv - serial bit-pattern detector with programmable pattern, length and overlap mode
//
// Purpose : shifts valid serial bits into a window and pulses y when the
//           last len bits equal the loaded pattern.
// Ports   : clk, rst_n (async active-low), x / x_vld (serial data + qualifier),
//           load / pat_in / len_in / ovl_in (configuration, restarts detection),
//           y (registered one-cycle match pulse), armed (state is HUNT),
//           match_cnt (saturating match count, only with PATDET_COUNT_EN).
// Config  : define PATDET_COUNT_EN to add the match_cnt port and counter.

module pattern_detector #(
   parameter int PAT_W = 4,
   parameter int LEN_W = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             x,
   input  logic             x_vld,
   input  logic             load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic [LEN_W-1:0] len_in,
   input  logic             ovl_in,
   output logic             y,
   output logic             armed
`ifdef PATDET_COUNT_EN
   ,
   output logic [CNT_W-1:0] match_cnt
`endif
);

   typedef enum logic [1:0] {
      S_UNCFG = 2'd0,
      S_FILL  = 2'd1,
      S_HUNT  = 2'd2
   } state_t;

   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [PAT_W-1:0] r_win;
   logic [PAT_W-1:0] r_pat;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_fill;
   logic             r_ovl;
   logic             r_y;

   logic             w_take;
   logic [PAT_W-1:0] w_win_nxt;
   logic [LEN_W-1:0] w_fill_nxt;
   logic [LEN_W-1:0] w_len_eff;
   logic [PAT_W-1:0] w_one;
   logic [PAT_W-1:0] w_mask;
   logic             w_full;
   logic             w_match;

   // Lengths below 2 or above PAT_W are meaningless; fall back to full width.
   assign w_len_eff = (len_in < LEN_W'(2) || len_in > LEN_MAX) ? LEN_MAX : len_in;

   // A bit is consumed only once configured, and load always wins over data.
   assign w_take     = x_vld && !load && (r_state != S_UNCFG);
   assign w_win_nxt  = {r_win[PAT_W-2:0], x};
   assign w_fill_nxt = (r_fill == r_len) ? r_len : r_fill + LEN_W'(1);
   assign w_full     = (w_fill_nxt == r_len);

   // Mask of the low r_len bits; when r_len == PAT_W the shift wraps to 0
   // and the subtraction yields all ones, which is exactly what is wanted.
   assign w_one   = PAT_W'(1);
   assign w_mask  = (w_one << r_len) - w_one;
   assign w_match = w_take && w_full && (((w_win_nxt ^ r_pat) & w_mask) == '0);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_UNCFG;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_UNCFG: begin
            if (load) w_state_nxt = S_FILL;
         end
         S_FILL, S_HUNT: begin
            if (load) begin
               w_state_nxt = S_FILL;
            end else if (w_take) begin
               if (w_match && !r_ovl) w_state_nxt = S_FILL;
               else if (w_full)       w_state_nxt = S_HUNT;
            end
         end
         default: w_state_nxt = S_UNCFG;
      endcase
   end

   // Output logic
   always_comb begin
      armed = (r_state == S_HUNT);
      y     = r_y;
   end

   // Datapath: configuration, window, fill count and match pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pat  <= '0;
         r_len  <= LEN_MAX;
         r_ovl  <= 1'b0;
         r_win  <= '0;
         r_fill <= '0;
         r_y    <= 1'b0;
      end else if (load) begin
         r_pat  <= pat_in;
         r_len  <= w_len_eff;
         r_ovl  <= ovl_in;
         r_win  <= '0;
         r_fill <= '0;
         r_y    <= 1'b0;
      end else begin
         r_y <= w_match;
         if (w_take) begin
            // Non-overlapping mode: a match consumes its bits.
            if (w_match && !r_ovl) begin
               r_win  <= '0;
               r_fill <= '0;
            end else begin
               r_win  <= w_win_nxt;
               r_fill <= w_fill_nxt;
            end
         end
      end
   end

`ifdef PATDET_COUNT_EN
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= '0;
      end else if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign match_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_pattern_detector.sv
// tb/tb_pattern_detector.sv - directed table-driven bench for pattern_detector

module tb_pattern_detector;

   localparam int PAT_W = 4;
   localparam int LEN_W = 3;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             x = 1'b0;
   logic             x_vld = 1'b0;
   logic             load = 1'b0;
   logic [PAT_W-1:0] pat_in = '0;
   logic [LEN_W-1:0] len_in = '0;
   logic             ovl_in = 1'b0;
   logic             y;
   logic             armed;
`ifdef PATDET_COUNT_EN
   logic [CNT_W-1:0] match_cnt;
`endif

   int total = 0;
   int bad = 0;

   pattern_detector #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .x      (x),
      .x_vld  (x_vld),
      .load   (load),
      .pat_in (pat_in),
      .len_in (len_in),
      .ovl_in (ovl_in),
      .y      (y),
      .armed  (armed)
`ifdef PATDET_COUNT_EN
      ,
      .match_cnt (match_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       ld;
      logic [3:0] pat;
      logic [2:0] len;
      logic       ovl;
      logic       vld;
      logic       xb;
      logic       ey;
      logic       ea;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk_load(logic [3:0] p, logic [2:0] l, logic o);
      vec_t v;
      v = '{ld:1'b1, pat:p, len:l, ovl:o, vld:1'b0, xb:1'b0, ey:1'b0, ea:1'b0};
      return v;
   endfunction

   function automatic vec_t mk_bit(logic vld, logic b, logic ey, logic ea);
      vec_t v;
      v = '{ld:1'b0, pat:4'h0, len:3'd0, ovl:1'b0, vld:vld, xb:b, ey:ey, ea:ea};
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ld, input logic [3:0] p, input logic [2:0] l,
                        input logic o, input logic vld, input logic b);
      @(negedge clk);
      load   = ld;
      pat_in = p;
      len_in = l;
      ovl_in = o;
      x_vld  = vld;
      x      = b;
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic b, input logic ey, input logic ea, input string name);
      drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b1, b);
      chk({name, ".y"}, 32'(y), 32'(ey));
      chk({name, ".armed"}, 32'(armed), 32'(ea));
   endtask

   initial begin
      // Stream while unconfigured is ignored
      vq.push_back(mk_bit(1, 1, 0, 0));
      // Overlap, pat 101 (len 3)
      vq.push_back(mk_load(4'b0101, 3'd3, 1'b1));
      vq.push_back(mk_bit(1, 1, 0, 0));
      vq.push_back(mk_bit(1, 0, 0, 0));
      vq.push_back(mk_bit(1, 1, 1, 1));
      vq.push_back(mk_bit(1, 0, 0, 1));
      vq.push_back(mk_bit(1, 1, 1, 1));
      // Non-overlap: 1,0,1,0,1,1,0,1 -> pulses on 3rd and 8th
      vq.push_back(mk_load(4'b0101, 3'd3, 1'b0));
      vq.push_back(mk_bit(1, 1, 0, 0));
      vq.push_back(mk_bit(1, 0, 0, 0));
      vq.push_back(mk_bit(1, 1, 1, 0));
      vq.push_back(mk_bit(1, 0, 0, 0));
      vq.push_back(mk_bit(1, 1, 0, 0));
      vq.push_back(mk_bit(1, 1, 0, 1));
      vq.push_back(mk_bit(1, 0, 0, 1));
      vq.push_back(mk_bit(1, 1, 1, 0));
      // Idle cycles ignored
      vq.push_back(mk_load(4'b0101, 3'd3, 1'b1));
      vq.push_back(mk_bit(1, 1, 0, 0));
      vq.push_back(mk_bit(0, 0, 0, 0));
      vq.push_back(mk_bit(0, 0, 0, 0));
      vq.push_back(mk_bit(0, 0, 0, 0));
      vq.push_back(mk_bit(1, 0, 0, 0));
      vq.push_back(mk_bit(1, 1, 1, 1));
      vq.push_back(mk_bit(0, 1, 0, 1));
      // len 0 clamps to 4: pattern 0110
      vq.push_back(mk_load(4'b0110, 3'd0, 1'b1));
      vq.push_back(mk_bit(1, 0, 0, 0));
      vq.push_back(mk_bit(1, 1, 0, 0));
      vq.push_back(mk_bit(1, 1, 0, 0));
      vq.push_back(mk_bit(1, 0, 1, 1));
      // len 1 clamps to 4, non-overlap: pattern 1001
      vq.push_back(mk_load(4'b1001, 3'd1, 1'b0));
      vq.push_back(mk_bit(1, 1, 0, 0));
      vq.push_back(mk_bit(1, 0, 0, 0));
      vq.push_back(mk_bit(1, 0, 0, 0));
      vq.push_back(mk_bit(1, 1, 1, 0));
      // len 7 clamps to 4, overlap: back-to-back pulses on 1111
      vq.push_back(mk_load(4'b1111, 3'd7, 1'b1));
      vq.push_back(mk_bit(1, 1, 0, 0));
      vq.push_back(mk_bit(1, 1, 0, 0));
      vq.push_back(mk_bit(1, 1, 0, 0));
      vq.push_back(mk_bit(1, 1, 1, 1));
      vq.push_back(mk_bit(1, 1, 1, 1));
      // Minimum length 2, pattern 10
      vq.push_back(mk_load(4'b0110, 3'd2, 1'b1));
      vq.push_back(mk_bit(1, 1, 0, 0));
      vq.push_back(mk_bit(1, 0, 1, 1));
      vq.push_back(mk_bit(1, 1, 0, 1));
      vq.push_back(mk_bit(1, 0, 1, 1));
      // Load from HUNT drops armed and restarts
      vq.push_back(mk_load(4'b0101, 3'd3, 1'b1));
      vq.push_back(mk_bit(1, 1, 0, 0));
      vq.push_back(mk_bit(1, 0, 0, 0));
      vq.push_back(mk_bit(1, 1, 1, 1));

      // Reset state
      #12;
      chk("reset.y", 32'(y), 32'd0);
      chk("reset.armed", 32'(armed), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vq[i]) begin
         drive(vq[i].ld, vq[i].pat, vq[i].len, vq[i].ovl, vq[i].vld, vq[i].xb);
         chk($sformatf("vec%0d.y", i), 32'(y), 32'(vq[i].ey));
         chk($sformatf("vec%0d.armed", i), 32'(armed), 32'(vq[i].ea));
      end

      // load with x_vld=1 mid-stream: bit discarded, fill restarts
      drive(1'b1, 4'b0101, 3'd3, 1'b1, 1'b0, 1'b0);
      feed(1'b1, 1'b0, 1'b0, "ldv.b1");
      feed(1'b0, 1'b0, 1'b0, "ldv.b2");
      drive(1'b1, 4'b0101, 3'd3, 1'b1, 1'b1, 1'b1);
      chk("ldv.load.y", 32'(y), 32'd0);
      chk("ldv.load.armed", 32'(armed), 32'd0);
      feed(1'b1, 1'b0, 1'b0, "ldv.b3");
      feed(1'b0, 1'b0, 1'b0, "ldv.b4");
      feed(1'b1, 1'b1, 1'b1, "ldv.b5");

      // Asynchronous reset mid-stream while y is high
      drive(1'b1, 4'b0101, 3'd3, 1'b1, 1'b0, 1'b0);
      feed(1'b1, 1'b0, 1'b0, "rst.b1");
      feed(1'b0, 1'b0, 1'b0, "rst.b2");
      feed(1'b1, 1'b1, 1'b1, "rst.b3");
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst.async.y", 32'(y), 32'd0);
      chk("rst.async.armed", 32'(armed), 32'd0);
      #3;
      rst_n = 1'b1;
      feed(1'b1, 1'b0, 1'b0, "rst.post1");
      feed(1'b0, 1'b0, 1'b0, "rst.post2");
      feed(1'b1, 1'b0, 1'b0, "rst.post3");

`ifdef PATDET_COUNT_EN
      // Counter saturates at 3 after five matches; load clears it
      drive(1'b1, 4'b0101, 3'd3, 1'b1, 1'b0, 1'b0);
      chk("cnt.after_load0", 32'(match_cnt), 32'd0);
      for (int k = 0; k < 11; k++) begin
         drive(1'b0, 4'h0, 3'd0, 1'b0, 1'b1, ~k[0]);
      end
      chk("cnt.sat", 32'(match_cnt), 32'd3);
      drive(1'b1, 4'b0101, 3'd3, 1'b1, 1'b0, 1'b0);
      chk("cnt.cleared", 32'(match_cnt), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not complete, expected finish before 50000");
      $fatal(1);
   end

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 SHALL have parameter PAT_W, default 4, maximum pattern length in bits (range 2..16).
REQ-002 SHALL have parameter LEN_W, default 3, width of the length field; 2**LEN_W > PAT_W SHALL hold.
REQ-003 SHALL have parameter CNT_W, default 8, match counter width (used only with PATDET_COUNT_EN).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port x  input  1  serial data bit.
REQ-007 SHALL have port x_vld  input  1  x is sampled only when high.
REQ-008 SHALL have port load  input  1  latch pat_in, len_in and ovl_in; restart detection.
REQ-009 SHALL have port pat_in  input  PAT_W  pattern, first-received bit at index len-1, last at index 0.
REQ-010 SHALL have port len_in  input  LEN_W  pattern length.
REQ-011 SHALL have port ovl_in  input  1  1 = overlapping matches, 0 = non-overlapping.
REQ-012 SHALL have port y  output  1  registered one-cycle match pulse.
REQ-013 SHALL have port armed  output  1  high while state is HUNT.
REQ-014 SHALL have port match_cnt  output  CNT_W  saturating match count (present only with PATDET_COUNT_EN).

Function
REQ-015 SHALL implement states UNCFG, FILL and HUNT.
REQ-016 UNCFG: y held 0, x ignored; exits only on load, to FILL.
REQ-017 On load: latch the pattern, the effective length and the overlap mode; clear the shift window and the fill count; enter FILL.
REQ-018 Effective length SHALL be len_in, except that len_in of 0, 1 or greater than PAT_W SHALL be clamped to PAT_W.
REQ-019 Each cycle with x_vld=1 and load=0 SHALL shift x into the window LSB and increment the fill count (saturating at the effective length).
REQ-020 FILL -> HUNT SHALL occur on the valid bit that makes fill count equal the effective length; that bit is also compared.
REQ-021 Match SHALL be defined as window[len-1:0] == pattern[len-1:0] on a valid bit when the fill count reaches or is at the effective length.
REQ-022 y SHALL be 1 in exactly the cycle after the matching bit is sampled, and 0 otherwise.
REQ-023 After a match with overlap=1, the state SHALL remain HUNT and the window SHALL be kept.
REQ-024 After a match with overlap=0, the window and fill count SHALL be cleared and the state SHALL go to FILL.
REQ-025 Cycles with x_vld=0 SHALL change no state, window or count; y SHALL be 0 in the following cycle.
REQ-026 load together with x_vld=1 SHALL favour load: the bit is discarded, y is 0 next cycle, and detection restarts.
REQ-027 load SHALL be accepted in any state, including mid-match.

Reset
REQ-028 rst_n=0 SHALL immediately force state UNCFG, y=0, armed=0, window=0, fill=0, pattern=0, length=PAT_W, overlap=0 and match_cnt=0.
REQ-029 Reset deassertion SHALL be usable on any clk edge; the first active edge afterwards evaluates with UNCFG state.

Configuration
REQ-030 Macro PATDET_COUNT_EN defined: match_cnt exists, increments by 1 per y pulse, saturates at 2**CNT_W-1, and is cleared by reset and by load.
REQ-031 Macro PATDET_COUNT_EN undefined: the match_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then load pat=0101, len=3, ovl=1; valid stream 1,0,1,0,1 -> y pulses after the 3rd and 5th bits; armed=1 from the 3rd bit onward.
REQ-033 Same load with ovl=0; valid stream 1,0,1,0,1,1,0,1 -> y pulses after the 3rd and 8th bits only.
REQ-034 len=3, ovl=1; stream 1,(x_vld=0, x=0) x3,0,1 -> a single y pulse after the final 1; idle cycles are ignored.
REQ-035 After the bits 1,0 are received, load with x_vld=1, x=1 -> no y, fill=0, and bits 1,0,1 are then needed for the next pulse.
REQ-036 rst_n low mid-stream -> y=0 immediately; after release, stream 1,0,1 gives no y until a new load.
REQ-037 With PATDET_COUNT_EN and CNT_W=2: five matches -> match_cnt=3, and a subsequent load returns it to 0.
